// File: rtl/message_parser.sv
// Line-oriented parser for ASCII '0'/'1' messages of MSG_LEN digits ended by CR or LF.
// Commits a complete message to bits_out with a one-cycle bits_valid; malformed lines pulse error.
module message_parser #(
    parameter int MSG_LEN = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               new_rx_data,
    output logic [MSG_LEN-1:0] bits_out,
    output logic               bits_valid,
    output logic               error,
    output logic               busy
);

    localparam int CW = $clog2(MSG_LEN + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, WAIT_EOL, DISCARD} state_t;
    typedef enum logic [1:0] {C_DIGIT, C_EOL, C_SPACE, C_OTHER} char_class_t;

    state_t             state;
    char_class_t        char_class;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_inc;
    logic [MSG_LEN-1:0] shift_reg;
    logic [MSG_LEN-1:0] shift_set;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        char_class = C_OTHER;
        if (rx_data == 8'h30 || rx_data == 8'h31)
            char_class = C_DIGIT;
        else if (rx_data == 8'h0D || rx_data == 8'h0A)
            char_class = C_EOL;
        else if (rx_data == 8'h20)
            char_class = C_SPACE;
    end

    // Shift register with the incoming digit written at position count.
    always_comb begin
        shift_set = shift_reg;
        for (int i = 0; i < MSG_LEN; i++)
            if (CW'(i) == count)
                shift_set[i] = rx_data[0];
    end

    assign count_inc = count + CW'(1);
    assign busy      = (state != IDLE);

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            shift_reg  <= '0;
            bits_out   <= '0;
            bits_valid <= 1'b0;
            error      <= 1'b0;
        end else begin
            bits_valid <= 1'b0;
            error      <= 1'b0;
            // Spaces are padding everywhere; in DISCARD they are dropped like any non-EOL.
            if (new_rx_data && char_class != C_SPACE) begin
                case (state)
                    IDLE: begin
                        if (char_class == C_DIGIT) begin
                            shift_reg <= MSG_LEN'(rx_data[0]);
                            count     <= CW'(1);
                            state     <= (CW'(1) == CW'(MSG_LEN)) ? WAIT_EOL : COLLECT;
                        end else if (char_class == C_OTHER) begin
                            error <= 1'b1;
                            state <= DISCARD;
                        end
                    end
                    COLLECT: begin
                        if (char_class == C_DIGIT) begin
                            shift_reg <= shift_set;
                            count     <= count_inc;
                            if (count_inc == CW'(MSG_LEN))
                                state <= WAIT_EOL;
                        end else begin
                            error <= 1'b1;
                            count <= '0;
                            state <= (char_class == C_EOL) ? IDLE : DISCARD;
                        end
                    end
                    WAIT_EOL: begin
                        count <= '0;
                        if (char_class == C_EOL) begin
                            bits_out   <= shift_reg;
                            bits_valid <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            error <= 1'b1;
                            state <= DISCARD;
                        end
                    end
                    DISCARD: begin
                        if (char_class == C_EOL)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_message_parser.sv
// Self-checking bench for message_parser: directed scenarios plus random lines
// compared against a line-oriented reference model.
module tb_message_parser;

    localparam int MSG_LEN = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [7:0]         rx_data;
    logic               new_rx_data;
    logic [MSG_LEN-1:0] bits_out;
    logic               bits_valid;
    logic               error;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: digits of the current line, whether the line is already bad,
    // and the last committed message.
    bit                 line_digits[$];
    bit                 line_bad;
    logic [MSG_LEN-1:0] exp_bits;

    message_parser #(.MSG_LEN(MSG_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .new_rx_data(new_rx_data),
        .bits_out   (bits_out),
        .bits_valid (bits_valid),
        .error      (error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic bit is_digit(input logic [7:0] c);
        return c == 8'h30 || c == 8'h31;
    endfunction

    function automatic bit is_eol(input logic [7:0] c);
        return c == 8'h0A || c == 8'h0D;
    endfunction

    task automatic model_reset();
        line_digits.delete();
        line_bad = 1'b0;
        exp_bits = '0;
    endtask

    // Decides what a character does from the whole line seen so far.
    task automatic model_step(input logic [7:0] c, output bit ev, output bit ee);
        ev = 1'b0;
        ee = 1'b0;
        if (c == 8'h20)
            return;
        if (is_eol(c)) begin
            if (!line_bad && line_digits.size() != 0) begin
                if (line_digits.size() == MSG_LEN) begin
                    exp_bits = '0;
                    foreach (line_digits[i]) exp_bits[i] = line_digits[i];
                    ev = 1'b1;
                end else begin
                    ee = 1'b1;
                end
            end
            line_bad = 1'b0;
            line_digits.delete();
        end else if (!line_bad) begin
            if (!is_digit(c) || line_digits.size() == MSG_LEN) begin
                ee       = 1'b1;
                line_bad = 1'b1;
                line_digits.delete();
            end else begin
                line_digits.push_back(c[0]);
            end
        end
    endtask

    function automatic bit model_busy();
        return line_bad || line_digits.size() != 0;
    endfunction

    // One strobe; outputs are checked #1 after the edge that samples it.
    task automatic send_char(input logic [7:0] c);
        bit ev, ee;
        @(negedge clk);
        rx_data     = c;
        new_rx_data = 1'b1;
        model_step(c, ev, ee);
        @(posedge clk);
        #1;
        new_rx_data = 1'b0;
        rx_data     = 8'($urandom);
        n_checks++;
        if (bits_valid !== ev) begin
            n_fail++;
            $display("FAIL bits_valid after char %02h: got %b expected %b", c, bits_valid, ev);
        end
        n_checks++;
        if (error !== ee) begin
            n_fail++;
            $display("FAIL error after char %02h: got %b expected %b", c, error, ee);
        end
        n_checks++;
        if (bits_out !== exp_bits) begin
            n_fail++;
            $display("FAIL bits_out after char %02h: got %02h expected %02h", c, bits_out, exp_bits);
        end
        n_checks++;
        if (busy !== model_busy()) begin
            n_fail++;
            $display("FAIL busy after char %02h: got %b expected %b", c, busy, model_busy());
        end
    endtask

    // Cycles without a strobe: no pulses, outputs hold, random junk on rx_data.
    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            rx_data = 8'($urandom);
            n_checks++;
            if (bits_valid !== 1'b0 || error !== 1'b0) begin
                n_fail++;
                $display("FAIL idle pulse: got valid=%b error=%b expected 0 0", bits_valid, error);
            end
            n_checks++;
            if (bits_out !== exp_bits || busy !== model_busy()) begin
                n_fail++;
                $display("FAIL idle hold: got bits_out=%02h busy=%b expected %02h %b",
                         bits_out, busy, exp_bits, model_busy());
            end
        end
    endtask

    // In directed strings '$' stands for LF and '#' for CR.
    task automatic send_str(input string s, input int gap);
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c == "$") c = 8'h0A;
            else if (c == "#") c = 8'h0D;
            send_char(c);
            if (gap > 0) idle_cycles(gap);
        end
    endtask

    task automatic expect_bits(input string name, input logic [MSG_LEN-1:0] want);
        n_checks++;
        if (bits_out !== want) begin
            n_fail++;
            $display("FAIL %s: got bits_out=%02h expected %02h", name, bits_out, want);
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        new_rx_data = 1'b0;
        rx_data     = 8'h00;
        model_reset();
        #3;
        n_checks++;
        if (bits_out !== '0 || bits_valid !== 1'b0 || error !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset state: got bits_out=%02h valid=%b error=%b busy=%b expected all 0",
                     bits_out, bits_valid, error, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_consecutive_commit();
        send_str("10110010$#", 0);
        expect_bits("commit_4d", 8'h4D);
        idle_cycles(2);
    endtask

    task automatic test_spaced_padding();
        send_str("0000 1111#", 3);
        expect_bits("commit_f0", 8'hF0);
    endtask

    task automatic test_short_message();
        send_str("101$", 1);
        expect_bits("short_keeps", 8'hF0);
    endtask

    task automatic test_garbage_then_valid();
        send_str("1x010101$", 0);
        send_str("11111111$", 0);
        expect_bits("commit_ff", 8'hFF);
    endtask

    task automatic test_overlength();
        send_str("111111111$", 0);
        expect_bits("overlength_keeps", 8'hFF);
    endtask

    task automatic test_async_reset();
        send_str("1010", 0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_mid_message: got %b expected 1", busy);
        end
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (bits_out !== '0 || bits_valid !== 1'b0 || error !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got bits_out=%02h valid=%b error=%b busy=%b expected all 0",
                     bits_out, bits_valid, error, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        // First edge after release samples the first strobe.
        send_str("01010101#", 0);
        expect_bits("commit_aa", 8'hAA);
    endtask

    task automatic test_back_to_back_random(input int n_lines);
        logic [7:0] q[$];
        int kind, len;
        for (int l = 0; l < n_lines; l++) begin
            q.delete();
            kind = $urandom_range(0, 4);
            case (kind)
                0: len = MSG_LEN;
                1: len = $urandom_range(1, MSG_LEN - 1);
                2: len = $urandom_range(MSG_LEN + 1, MSG_LEN + 3);
                default: len = $urandom_range(1, 12);
            endcase
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 4) == 0) q.push_back(8'h20);
                if (kind == 3 && $urandom_range(0, 2) == 0)
                    q.push_back(8'($urandom));
                else
                    q.push_back(8'h30 + 8'($urandom_range(0, 1)));
            end
            q.push_back($urandom_range(0, 1) ? 8'h0A : 8'h0D);
            if ($urandom_range(0, 1)) q.push_back($urandom_range(0, 1) ? 8'h0A : 8'h0D);
            foreach (q[i]) begin
                send_char(q[i]);
                idle_cycles($urandom_range(0, 2));
            end
        end
    endtask

    initial begin
        test_reset();
        test_consecutive_commit();
        test_spaced_padding();
        test_short_message();
        test_garbage_then_valid();
        test_overlength();
        test_async_reset();
        test_back_to_back_random(40);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
